// File: rtl/axi_sink_pkg.sv
// Shared types and AXI3 encodings for the burst write sink.
package axi_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/sink_strb_mem.sv
// Byte-enable word array with one write port and a registered read-before-write read port.
module sink_strb_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      we_i,
    input  logic [AW-1:0]             waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic [AW-1:0]             raddr_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_o <= '0;
        end else begin
            // Non-blocking read sees the pre-write contents on a same-word collision.
            rdata_o <= mem_q[raddr_i];
            if (we_i) begin
                for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/s_axi_burst_sink.sv
// AXI3 write-only slave: takes one burst at a time into a word array, answers with B and counts
// OKAY/SLVERR responses.
module s_axi_burst_sink
    import axi_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [3:0]                 awid_i,
    input  logic [63:0]                awaddr_i,
    input  logic [3:0]                 awlen_i,
    input  logic [2:0]                 awsize_i,
    input  logic [1:0]                 awburst_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [3:0]                 wid_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic [3:0]                 wstrb_i,
    input  logic                       wlast_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [3:0]                 bid_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    input  logic [$clog2(DEPTH)-1:0]   dbg_addr_i,
    output logic [DATA_WIDTH-1:0]      dbg_rdata_o,
    output logic [15:0]                burst_cnt_o,
    output logic [15:0]                err_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t      state_q;
    logic [3:0]  awid_q;
    logic [3:0]  awlen_q;
    logic [2:0]  awsize_q;
    logic [1:0]  awburst_q;
    logic [63:0] ptr_q;
    logic        aligned_q;
    logic [4:0]  beat_q;
    logic        err_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [3:0]  bid_q;
    logic [1:0]  bresp_q;
    logic [15:0] burst_cnt_q;
    logic [15:0] err_cnt_q;

    logic [63:0] aw_offset;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        burst_ok;
    logic        ptr_in_range;
    logic        beat_ok;
    logic        wlast_err;
    logic        wr_en;

    assign aw_offset    = awaddr_i - BASE_ADDR;
    assign aw_hs        = awvalid_i & awready_q;
    assign w_hs         = wvalid_i & wready_q;
    assign b_hs         = bvalid_q & bready_i;
    assign burst_ok     = (awburst_q == BURST_FIXED) || (awburst_q == BURST_INCR);
    assign ptr_in_range = ptr_q < 64'(DEPTH);
    assign beat_ok      = (awsize_q == SIZE_4B) && burst_ok && ptr_in_range && aligned_q &&
                          (wid_i == awid_q) && (beat_q <= {1'b0, awlen_q});
    assign wlast_err    = beat_q != {1'b0, awlen_q};
    assign wr_en        = w_hs & beat_ok;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= IDLE;
            awid_q      <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            ptr_q       <= '0;
            aligned_q   <= 1'b0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            burst_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        awid_q    <= awid_i;
                        awlen_q   <= awlen_i;
                        awsize_q  <= awsize_i;
                        awburst_q <= awburst_i;
                        ptr_q     <= aw_offset >> 2;
                        aligned_q <= aw_offset[1:0] == 2'b00;
                        beat_q    <= '0;
                        // WRAP and reserved bursts are rejected up front.
                        err_q     <= !((awburst_i == BURST_FIXED) || (awburst_i == BURST_INCR));
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        // Saturate so overlong bursts never alias back into the valid range.
                        if (beat_q != 5'h1f) begin
                            beat_q <= beat_q + 5'd1;
                        end
                        if (awburst_q == BURST_INCR && ptr_in_range) begin
                            ptr_q <= ptr_q + 64'd1;
                        end
                        err_q <= err_q | ~beat_ok;
                        if (wlast_i) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= awid_q;
                            bresp_q  <= (err_q | ~beat_ok | wlast_err) ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        bvalid_q <= 1'b0;
                        if (bresp_q == RESP_OKAY) begin
                            burst_cnt_q <= burst_cnt_q + 16'd1;
                        end else begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sink_strb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .areset  (areset),
        .we_i    (wr_en),
        .waddr_i (ptr_q[AW-1:0]),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .raddr_i (dbg_addr_i),
        .rdata_o (dbg_rdata_o)
    );

    assign awready_o   = awready_q;
    assign wready_o    = wready_q;
    assign bvalid_o    = bvalid_q;
    assign bid_o       = bid_q;
    assign bresp_o     = bresp_q;
    assign burst_cnt_o = burst_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
